// File: rtl/vga_timing_gen_if.sv
// Raster interface of vga_timing_gen.
// The master side (the timing generator) requests coordinates from a pixel
// source and drives the DAC. The slave side (pixel source plus DAC) returns
// colour and receives sync and RGB.
//   x, y         coordinate request
//   req_active   (x,y) lies in the visible area
//   line_start   1-tick strobe at x==0
//   frame_start  1-tick strobe at x==0, y==0
//   tick         pixel-tick enable
//   r_in/g_in/b_in  colour returned by the pixel source
//   hsync/vsync  registered sync to the DAC
//   r/g/b        registered colour to the DAC, zero while blanked
interface vga_timing_gen_if #(
  parameter int CNT_W   = 11,
  parameter int COLOR_W = 4
);
  logic [CNT_W-1:0]   x;
  logic [CNT_W-1:0]   y;
  logic               req_active;
  logic               line_start;
  logic               frame_start;
  logic               tick;
  logic [COLOR_W-1:0] r_in;
  logic [COLOR_W-1:0] g_in;
  logic [COLOR_W-1:0] b_in;
  logic               hsync;
  logic               vsync;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;

  modport master (
    output x, y, req_active, line_start, frame_start, tick,
    output hsync, vsync, r, g, b,
    input  r_in, g_in, b_in
  );

  modport slave (
    input  x, y, req_active, line_start, frame_start, tick,
    input  hsync, vsync, r, g, b,
    output r_in, g_in, b_in
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator and DAC output stage.
// Counts pixel ticks (clk divided by CLK_DIV), presents (x,y) to a pixel
// source, and registers the colour that source returns PIN_LAT ticks later,
// together with sync and blanking delayed by the same amount.
// Ports:
//   clk    system clock
//   clr_n  synchronous active-low reset
//   en     run enable; en=0 behaves like reset
//   bus    vga_timing_gen_if master: coordinates, strobes, tick, colour in,
//          hsync/vsync/RGB out
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 11,
  parameter int COLOR_W  = 4,
  parameter int PIN_LAT  = 1,
  parameter int CLK_DIV  = 1
) (
  input logic              clk,
  input logic              clr_n,
  input logic              en,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW1     = CNT_W + 1;

  if (PIN_LAT < 0 || PIN_LAT > 4) begin : g_bad_pin_lat
    $error("vga_timing_gen: PIN_LAT must be 0..4");
  end
  if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be 1..8");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2**CNT_W");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);

  // Segment bounds are compared one bit wider than the counters so that a
  // bound equal to 2**CNT_W (zero back porch at full width) stays exact.
  localparam logic [CW1-1:0] X_ACT    = CW1'(H_ACTIVE);
  localparam logic [CW1-1:0] HS_START = CW1'(H_ACTIVE + H_FP);
  localparam logic [CW1-1:0] HS_END   = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW1-1:0] Y_ACT    = CW1'(V_ACTIVE);
  localparam logic [CW1-1:0] VS_START = CW1'(V_ACTIVE + V_FP);
  localparam logic [CW1-1:0] VS_END   = CW1'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_LVL = (HS_POL != 0);
  localparam logic VS_LVL = (VS_POL != 0);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } ctl_t;

  logic [DIV_W-1:0]   div_q;
  logic [CNT_W-1:0]   x_q;
  logic [CNT_W-1:0]   y_q;
  logic [CW1-1:0]     x_ext;
  logic [CW1-1:0]     y_ext;
  logic               run;
  logic               tick;
  ctl_t               ctl_raw;
  ctl_t               ctl_dly;
  logic               hsync_q;
  logic               vsync_q;
  logic [COLOR_W-1:0] r_q;
  logic [COLOR_W-1:0] g_q;
  logic [COLOR_W-1:0] b_q;

  // Reset and disable share one path: either one parks everything at (0,0)
  // with blank outputs and restarts cleanly from the first tick.
  assign run   = clr_n & en;
  assign tick  = run & (div_q == DIV_LAST);
  assign x_ext = {1'b0, x_q};
  assign y_ext = {1'b0, y_q};

  assign ctl_raw.act = (x_ext < X_ACT) && (y_ext < Y_ACT);
  assign ctl_raw.hs  = (x_ext >= HS_START) && (x_ext < HS_END);
  assign ctl_raw.vs  = (y_ext >= VS_START) && (y_ext < VS_END);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register samples pre-edge values.
    if (!run) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      x_q <= '0;
      y_q <= '0;
    end else if (tick) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  // Delay line matching the pixel source latency.
  if (PIN_LAT == 0) begin : g_no_dly
    assign ctl_dly = ctl_raw;
  end else begin : g_dly
    ctl_t dly_q [PIN_LAT];

    always_ff @(posedge clk) begin
      // NOTE: this small shift register is reset on purpose; stale sync or
      // active bits would otherwise leak out after a mid-frame reset.
      if (!run) begin
        for (int i = 0; i < PIN_LAT; i++) dly_q[i] <= '0;
      end else if (tick) begin
        dly_q[0] <= ctl_raw;
        for (int i = 1; i < PIN_LAT; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign ctl_dly = dly_q[PIN_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      hsync_q <= ~HS_LVL;
      vsync_q <= ~VS_LVL;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else if (tick) begin
      hsync_q <= ctl_dly.hs ? HS_LVL : ~HS_LVL;
      vsync_q <= ctl_dly.vs ? VS_LVL : ~VS_LVL;
      r_q     <= ctl_dly.act ? bus.r_in : '0;
      g_q     <= ctl_dly.act ? bus.g_in : '0;
      b_q     <= ctl_dly.act ? bus.b_in : '0;
    end
  end

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.req_active  = run & ctl_raw.act;
  assign bus.tick        = tick;
  assign bus.line_start  = tick & (x_q == '0);
  assign bus.frame_start = tick & (x_q == '0) & (y_q == '0);
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.r           = r_q;
  assign bus.g           = g_q;
  assign bus.b           = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with three instances:
//   dut_a  default 640x480, PIN_LAT=1, CLK_DIV=1, active-low syncs
//   dut_b  16x8 toy raster, PIN_LAT=2, CLK_DIV=4, active-high syncs, CNT_W=4
//   dut_c  800x600 set, PIN_LAT=0, active-high syncs
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_a, en_a, clr_b, en_b, clr_c, en_c;
  int n_run  = 0;
  int n_fail = 0;

  vga_timing_gen_if #(.CNT_W(11), .COLOR_W(4)) bus_a ();
  vga_timing_gen_if #(.CNT_W(4),  .COLOR_W(4)) bus_b ();
  vga_timing_gen_if #(.CNT_W(11), .COLOR_W(4)) bus_c ();

  vga_timing_gen dut_a (.clk(clk), .clr_n(clr_a), .en(en_a), .bus(bus_a.master));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CNT_W(4), .COLOR_W(4),
    .PIN_LAT(2), .CLK_DIV(4)
  ) dut_b (.clk(clk), .clr_n(clr_b), .en(en_b), .bus(bus_b.master));

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HS_POL(1), .VS_POL(1), .CNT_W(11), .COLOR_W(4),
    .PIN_LAT(0), .CLK_DIV(1)
  ) dut_c (.clk(clk), .clr_n(clr_c), .en(en_c), .bus(bus_c.master));

  // Pixel source for dut_a: one-tick latency, colour derived from (x,y).
  always @(posedge clk) begin
    if (bus_a.tick) begin
      bus_a.r_in <= bus_a.x[3:0];
      bus_a.g_in <= bus_a.y[3:0];
      bus_a.b_in <= bus_a.x[7:4];
    end
  end

  // Constant source for dut_b: only blanking and alignment matter there.
  assign bus_b.r_in = 4'hA;
  assign bus_b.g_in = 4'h5;
  assign bus_b.b_in = 4'h3;

  // Zero-latency source for dut_c.
  assign bus_c.r_in = bus_c.x[3:0];
  assign bus_c.g_in = bus_c.y[3:0];
  assign bus_c.b_in = 4'h9;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit at_xy(input int dut, input int xv, input int yv);
    case (dut)
      0:       return (int'(bus_a.x) == xv) && (int'(bus_a.y) == yv);
      1:       return (int'(bus_b.x) == xv) && (int'(bus_b.y) == yv);
      default: return (int'(bus_c.x) == xv) && (int'(bus_c.y) == yv);
    endcase
  endfunction

  // Advance until the first cycle showing (xv,yv); an expired budget is a failure.
  task automatic wait_xy(input int dut, input int xv, input int yv, input int budget);
    int cnt = 0;
    while (!at_xy(dut, xv, yv) && cnt < budget) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check($sformatf("reach_d%0d_x%0d_y%0d", dut, xv, yv), {31'd0, at_xy(dut, xv, yv)}, 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clr_a = 1'b0; en_a = 1'b1;
    clr_b = 1'b0; en_b = 1'b0;
    clr_c = 1'b0; en_c = 1'b0;
    step(3);

    // ---- dut_a: reset state
    check("a_rst_x",      bus_a.x, 0);
    check("a_rst_y",      bus_a.y, 0);
    check("a_rst_hsync",  bus_a.hsync, 1);
    check("a_rst_vsync",  bus_a.vsync, 1);
    check("a_rst_r",      bus_a.r, 0);
    check("a_rst_req",    bus_a.req_active, 0);
    check("a_rst_tick",   bus_a.tick, 0);
    check("a_rst_fstart", bus_a.frame_start, 0);

    clr_a = 1'b1;
    #1;
    check("a_rel_fstart", bus_a.frame_start, 1);
    check("a_rel_tick",   bus_a.tick, 1);
    check("a_rel_req",    bus_a.req_active, 1);

    // ---- dut_a: hsync low for x in 658..753 (two ticks behind hs_raw)
    wait_xy(0, 657, 0, 1000);
    check("a_hs_657", bus_a.hsync, 1);
    step(1);
    check("a_hs_658", bus_a.hsync, 0);
    step(95);
    check("a_hs_753", bus_a.hsync, 0);
    step(1);
    check("a_hs_754", bus_a.hsync, 1);
    check("a_vs_line0", bus_a.vsync, 1);

    // ---- dut_a: line 1 strobes and colour alignment (r = (x-2)[3:0])
    wait_xy(0, 0, 1, 200);
    check("a_lstart_y1", bus_a.line_start, 1);
    check("a_fstart_y1", bus_a.frame_start, 0);
    check("a_r_blank_x0", bus_a.r, 0);
    step(1);
    check("a_r_blank_x1", bus_a.r, 0);
    step(2);
    check("a_r_x3", bus_a.r, 1);
    check("a_g_x3", bus_a.g, 1);
    check("a_b_x3", bus_a.b, 0);
    wait_xy(0, 639, 1, 800);
    check("a_req_639", bus_a.req_active, 1);
    step(1);
    check("a_req_640", bus_a.req_active, 0);
    step(1);
    check("a_r_x641", bus_a.r, 15);
    check("a_g_x641", bus_a.g, 1);
    check("a_b_x641", bus_a.b, 7);
    step(2);
    check("a_r_blank_x643", bus_a.r, 0);
    wait_xy(0, 657, 1, 100);
    check("a_hs_period_657", bus_a.hsync, 1);
    step(1);
    check("a_hs_period_658", bus_a.hsync, 0);

    // ---- dut_a: mid-frame reset held for three edges
    wait_xy(0, 300, 2, 2000);
    check("a_r_x300", bus_a.r, 10);
    clr_a = 1'b0;
    #1;
    check("a_clr_tick", bus_a.tick, 0);
    check("a_clr_req",  bus_a.req_active, 0);
    step(1);
    check("a_clr_x",     bus_a.x, 0);
    check("a_clr_y",     bus_a.y, 0);
    check("a_clr_r",     bus_a.r, 0);
    check("a_clr_hsync", bus_a.hsync, 1);
    step(2);
    check("a_clr_fstart", bus_a.frame_start, 0);
    clr_a = 1'b1;
    #1;
    check("a_clr_rel_fstart", bus_a.frame_start, 1);

    // ---- dut_a: enable dropped during the hsync pulse
    wait_xy(0, 700, 0, 1000);
    check("a_en_hs_before", bus_a.hsync, 0);
    en_a = 1'b0;
    #1;
    check("a_en_tick_now", bus_a.tick, 0);
    step(1);
    check("a_en_hsync", bus_a.hsync, 1);
    check("a_en_x",     bus_a.x, 0);
    step(4);
    check("a_en_tick_held",  bus_a.tick, 0);
    check("a_en_lstart",     bus_a.line_start, 0);
    check("a_en_x_held",     bus_a.x, 0);
    en_a = 1'b1;
    #1;
    check("a_reen_fstart", bus_a.frame_start, 1);
    step(1);
    check("a_reen_x1", bus_a.x, 1);

    // ---- dut_b: reset values with active-high syncs
    check("b_rst_hsync", bus_b.hsync, 0);
    check("b_rst_vsync", bus_b.vsync, 0);
    clr_b = 1'b1;
    en_b  = 1'b1;
    #1;
    check("b_rel_tick",   bus_b.tick, 0);
    check("b_rel_fstart", bus_b.frame_start, 0);
    step(3);
    check("b_tick_3",   bus_b.tick, 1);
    check("b_fstart_3", bus_b.frame_start, 1);
    check("b_x_3",      bus_b.x, 0);
    step(1);
    check("b_x_4",    bus_b.x, 1);
    check("b_tick_4", bus_b.tick, 0);
    n = 1;
    while (!bus_b.frame_start && n < 1000) begin
      step(1);
      n++;
    end
    check("b_frame_cycles", n, 512);

    // hsync high for x 13..15 (three ticks behind hs_raw), stable for 4 clocks
    wait_xy(1, 12, 0, 100);
    check("b_hs_12", bus_b.hsync, 0);
    wait_xy(1, 13, 0, 10);
    check("b_hs_13", bus_b.hsync, 1);
    step(3);
    check("b_hs_13_hold", bus_b.hsync, 1);
    wait_xy(1, 0, 1, 20);
    check("b_hs_end", bus_b.hsync, 0);
    check("b_r_blank_x0", bus_b.r, 0);
    check("b_lstart_pre", bus_b.line_start, 0);
    step(3);
    check("b_lstart", bus_b.line_start, 1);
    wait_xy(1, 3, 1, 20);
    check("b_r_x3", bus_b.r, 10);
    check("b_g_x3", bus_b.g, 5);
    wait_xy(1, 7, 1, 20);
    check("b_req_7", bus_b.req_active, 1);
    wait_xy(1, 8, 1, 10);
    check("b_req_8", bus_b.req_active, 0);
    wait_xy(1, 10, 1, 20);
    check("b_r_x10", bus_b.r, 10);
    step(4);
    check("b_r_blank_x11", bus_b.r, 0);
    check("b_b_blank_x11", bus_b.b, 0);
    wait_xy(1, 5, 4, 300);
    check("b_r_blank_line4", bus_b.r, 0);
    wait_xy(1, 2, 5, 100);
    check("b_vs_y5_x2", bus_b.vsync, 0);
    step(4);
    check("b_vs_y5_x3", bus_b.vsync, 1);
    wait_xy(1, 2, 7, 200);
    check("b_vs_y7_x2", bus_b.vsync, 1);
    step(4);
    check("b_vs_y7_x3", bus_b.vsync, 0);

    // ---- dut_c: 800x600, zero latency, active-high syncs
    clr_c = 1'b1;
    en_c  = 1'b1;
    #1;
    check("c_rel_fstart", bus_c.frame_start, 1);
    wait_xy(2, 5, 0, 20);
    check("c_r_x5",   bus_c.r, 4);
    check("c_g_x5",   bus_c.g, 0);
    check("c_req_x5", bus_c.req_active, 1);
    wait_xy(2, 800, 0, 900);
    check("c_r_x800",   bus_c.r, 15);
    check("c_req_x800", bus_c.req_active, 0);
    step(2);
    check("c_r_blank_x802", bus_c.r, 0);
    wait_xy(2, 840, 0, 100);
    check("c_hs_840", bus_c.hsync, 0);
    step(1);
    check("c_hs_841", bus_c.hsync, 1);
    wait_xy(2, 968, 0, 200);
    check("c_hs_968", bus_c.hsync, 1);
    step(1);
    check("c_hs_969", bus_c.hsync, 0);
    wait_xy(2, 0, 1, 200);
    check("c_r_blank_x0", bus_c.r, 0);
    check("c_lstart", bus_c.line_start, 1);
    check("c_vs_y1",  bus_c.vsync, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
